// File: rtl/dsp_scan_pkg.sv
// Shared FSM encodings, widths and the channel-index width helper for dsp_rate_scanner.
package dsp_scan_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_DISCARD = 3'd2;
  localparam logic [2:0] ST_MEASURE = 3'd3;
  localparam logic [2:0] ST_STORE   = 3'd4;

  typedef enum logic [2:0] {
    SCAN_IDLE    = ST_IDLE,
    SCAN_LOAD    = ST_LOAD,
    SCAN_DISCARD = ST_DISCARD,
    SCAN_MEASURE = ST_MEASURE,
    SCAN_STORE   = ST_STORE
  } scan_state_e;

  localparam int IVL_W = 24;
  localparam int RES_W = 25;

  // A 2-channel scanner still needs a 1-bit index.
  function automatic int chw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dsp_timed_counter.sv
// Counts count_in over back-to-back windows of `interval` clocks (0 = 2^24) and
// publishes each window total with a one-cycle count_out_valid.
module dsp_timed_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        interval_load,
  input  logic [23:0] interval,
  input  logic        count_in,
  output logic [24:0] count_out,
  output logic        count_out_valid
);

  logic        run_q, run_d;
  logic [24:0] len_q, len_d;
  logic [24:0] tmr_q, tmr_d;
  logic [24:0] acc_q, acc_d;
  logic [24:0] out_q, out_d;
  logic        vld_q, vld_d;
  logic [24:0] acc_inc;

  // The load cycle itself is not counted; the first window starts the cycle after.
  always_comb begin
    run_d   = run_q;
    len_d   = len_q;
    tmr_d   = tmr_q;
    acc_d   = acc_q;
    out_d   = out_q;
    vld_d   = 1'b0;
    acc_inc = acc_q + {24'd0, count_in};
    if (interval_load) begin
      run_d = 1'b1;
      len_d = (interval == 24'd0) ? 25'h100_0000 : {1'b0, interval};
      tmr_d = '0;
      acc_d = '0;
    end else if (run_q) begin
      if (tmr_q == len_q - 25'd1) begin
        out_d = acc_inc;
        vld_d = 1'b1;
        tmr_d = '0;
        acc_d = '0;
      end else begin
        tmr_d = tmr_q + 25'd1;
        acc_d = acc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      len_q <= 25'h100_0000;
      tmr_q <= '0;
      acc_q <= '0;
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      run_q <= run_d;
      len_q <= len_d;
      tmr_q <= tmr_d;
      acc_q <= acc_d;
      out_q <= out_d;
      vld_q <= vld_d;
    end
  end

  assign count_out       = out_q;
  assign count_out_valid = vld_q;

endmodule

// File: rtl/dsp_rate_scanner.sv
// Multi-channel rate scanner: measures each trig_in channel over one timed interval
// in turn. Optional threshold flags build with RATE_SCANNER_THRESH_EN.
module dsp_rate_scanner
  import dsp_scan_pkg::*;
#(
  parameter int          NCHAN         = 8,
  parameter logic [23:0] INTERVAL_INIT = 24'd125000,
  localparam int         CHW           = chw(NCHAN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCHAN-1:0] trig_in,
  input  logic [23:0]      interval_in,
  input  logic             interval_wr,
  input  logic             start,
  input  logic             continuous,
  input  logic             stop,
  output logic             busy,
  output logic             scan_done,
  output logic [CHW-1:0]   cur_chan,
  input  logic [CHW-1:0]   rd_addr,
  output logic [24:0]      rd_data,
`ifdef RATE_SCANNER_THRESH_EN
  input  logic [24:0]      thresh_in,
  output logic [NCHAN-1:0] over_mask,
`endif
  output logic [2:0]       state_dbg
);

  localparam logic [CHW-1:0] LAST_CHAN = CHW'(NCHAN - 1);

  logic [2:0]       state_q, state_d;
  logic [CHW-1:0]   chan_q, chan_d;
  logic             stop_pend_q, stop_pend_d;
  logic [23:0]      ivl_q, ivl_d;
  logic             cin_q, cin_d;
  logic [24:0]      rd_data_q, rd_data_d;
  logic [RES_W-1:0] res_q [NCHAN];
  logic [RES_W-1:0] res_d [NCHAN];
  logic             cnt_load;
  logic [24:0]      cnt_out;
  logic             cnt_vld;

  dsp_timed_counter u_cnt (
    .clk             (clk),
    .rst_n           (rst_n),
    .interval_load   (cnt_load),
    .interval        (ivl_d),
    .count_in        (cin_q),
    .count_out       (cnt_out),
    .count_out_valid (cnt_vld)
  );

  // A write in the same cycle as LOAD is forwarded so the new interval takes effect at once.
  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    stop_pend_d = stop_pend_q;
    ivl_d       = interval_wr ? interval_in : ivl_q;
    cin_d       = trig_in[chan_q];
    res_d       = res_q;
    cnt_load    = 1'b0;
    if (stop && state_q != ST_IDLE) stop_pend_d = 1'b1;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        cnt_load = 1'b1;
        state_d  = ST_DISCARD;
      end
      ST_DISCARD: begin
        if (interval_wr)  state_d = ST_LOAD;
        else if (cnt_vld) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (interval_wr) begin
          state_d = ST_LOAD;
        end else if (cnt_vld) begin
          res_d[chan_q] = cnt_out;
          state_d       = ST_STORE;
        end
      end
      ST_STORE: begin
        if (chan_q != LAST_CHAN) begin
          chan_d  = chan_q + CHW'(1);
          state_d = ST_LOAD;
        end else begin
          chan_d  = '0;
          state_d = (continuous && !stop_pend_d) ? ST_LOAD : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE) stop_pend_d = 1'b0;
  end

  always_comb begin
    rd_data_d = '0;
    if (int'(rd_addr) < NCHAN) rd_data_d = res_q[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      chan_q      <= '0;
      stop_pend_q <= 1'b0;
      ivl_q       <= INTERVAL_INIT;
      cin_q       <= 1'b0;
      rd_data_q   <= '0;
      for (int i = 0; i < NCHAN; i++) res_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      stop_pend_q <= stop_pend_d;
      ivl_q       <= ivl_d;
      cin_q       <= cin_d;
      rd_data_q   <= rd_data_d;
      res_q       <= res_d;
    end
  end

`ifdef RATE_SCANNER_THRESH_EN
  logic [NCHAN-1:0] over_q, over_d;

  always_comb begin
    over_d = over_q;
    if (state_q == ST_STORE) over_d[chan_q] = (res_q[chan_q] > thresh_in);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) over_q <= '0;
    else        over_q <= over_d;
  end

  assign over_mask = over_q;
`endif

  assign busy      = (state_q != ST_IDLE);
  assign scan_done = (state_q == ST_STORE) && (chan_q == LAST_CHAN);
  assign cur_chan  = chan_q;
  assign rd_data   = rd_data_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_dsp_rate_scanner.sv
// Directed bench for dsp_rate_scanner (NCHAN=4); threshold checks compile in with
// RATE_SCANNER_THRESH_EN.
module tb_dsp_rate_scanner;

  localparam int NCH = 4;

  typedef struct packed {
    logic [3:0]       trig;
    logic [23:0]      ivl;
    logic [3:0][24:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  trig_drv = '0;
  logic [3:0]  trig_w;
  logic [23:0] interval_in = '0;
  logic        interval_wr = 1'b0;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic        stop = 1'b0;
  logic        busy, scan_done;
  logic [1:0]  cur_chan;
  logic [1:0]  rd_addr = '0;
  logic [24:0] rd_data;
  logic [2:0]  state_dbg;
`ifdef RATE_SCANNER_THRESH_EN
  logic [24:0] thresh_in = 25'd5;
  logic [3:0]  over_mask;
`endif

  logic tog_en = 1'b0;
  logic tog_bit = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   done_cnt = 0;

  assign trig_w = trig_drv ^ {2'b00, tog_bit, 1'b0};

  dsp_rate_scanner #(.NCHAN(NCH), .INTERVAL_INIT(24'd125000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .trig_in     (trig_w),
    .interval_in (interval_in),
    .interval_wr (interval_wr),
    .start       (start),
    .continuous  (continuous),
    .stop        (stop),
    .busy        (busy),
    .scan_done   (scan_done),
    .cur_chan    (cur_chan),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
`ifdef RATE_SCANNER_THRESH_EN
    .thresh_in   (thresh_in),
    .over_mask   (over_mask),
`endif
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && scan_done) done_cnt++;

  always @(negedge clk) tog_bit <= tog_en ? ~tog_bit : 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic set_ivl(input logic [23:0] ivl);
    @(negedge clk);
    interval_in = ivl;
    interval_wr = 1'b1;
    @(negedge clk);
    interval_wr = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  // Counts busy cycles starting at the LOAD cycle that follows pulse_start.
  task automatic wait_idle(input string name, output int cyc);
    cyc = 0;
    while (busy && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 5000) check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic rd(input int a, output logic [24:0] d);
    @(negedge clk);
    rd_addr = a[1:0];
    @(negedge clk);
    d = rd_data;
  endtask

  function automatic vec_t mk(input logic [3:0] trig, input logic [23:0] ivl,
                              input int e3, input int e2, input int e1, input int e0);
    vec_t v;
    v.trig   = trig;
    v.ivl    = ivl;
    v.exp[3] = 25'(e3);
    v.exp[2] = 25'(e2);
    v.exp[1] = 25'(e1);
    v.exp[0] = 25'(e0);
    return v;
  endfunction

  initial begin
    vec_t        vecs[4];
    logic [24:0] d;
    int          cyc, d0, cnt;

    vecs[0] = mk(4'b1000, 24'd10, 10, 0, 0, 0);
    vecs[1] = mk(4'b0101, 24'd7,  0, 7, 0, 7);
    vecs[2] = mk(4'b1111, 24'd3,  3, 3, 3, 3);
    vecs[3] = mk(4'b0110, 24'd1,  0, 1, 1, 0);

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_scan_done", 32'(scan_done), 0);
    check("rst_cur_chan", 32'(cur_chan), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_state", 32'(state_dbg), 0);
`ifdef RATE_SCANNER_THRESH_EN
    check("rst_over_mask", 32'(over_mask), 0);
`endif
    rst_n = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      rd(c, d);
      check($sformatf("rst_res%0d", c), 32'(d), 0);
    end

    // Start in IDLE with stop: stop must be ignored, nothing starts.
    pulse_stop();
    check("idle_stop_busy", 32'(busy), 0);

    for (int v = 0; v < 4; v++) begin
      d0 = done_cnt;
      @(negedge clk);
      trig_drv = vecs[v].trig;
      set_ivl(vecs[v].ivl);
      pulse_start();
      wait_idle("vec", cyc);
      check_rng($sformatf("vec%0d_scan_cycles", v), cyc,
                NCH * (2 * int'(vecs[v].ivl) + 2) - 2 * NCH,
                NCH * (2 * int'(vecs[v].ivl) + 2) + 2 * NCH);
      check($sformatf("vec%0d_done_pulses", v), 32'(done_cnt - d0), 1);
      check($sformatf("vec%0d_cur_chan", v), 32'(cur_chan), 0);
      for (int c = 0; c < NCH; c++) begin
        rd(c, d);
        check($sformatf("vec%0d_res%0d", v, c), 32'(d), 32'(vecs[v].exp[c]));
      end
`ifdef RATE_SCANNER_THRESH_EN
      for (int c = 0; c < NCH; c++)
        check($sformatf("vec%0d_over%0d", v, c), 32'(over_mask[c]),
              32'(vecs[v].exp[c] > thresh_in));
`endif
    end

    // Channel 1 toggling every clock over a 20-clock window.
    @(negedge clk);
    trig_drv = 4'b0000;
    tog_en   = 1'b1;
    set_ivl(24'd20);
    pulse_start();
    wait_idle("tog", cyc);
    tog_en = 1'b0;
    rd(1, d);
    check_rng("tog_res1", int'(d), 9, 11);
    rd(0, d);
    check("tog_res0", 32'(d), 0);

    // Continuous scan, stop during channel 1: finishes the scan, then idles.
    d0 = done_cnt;
    @(negedge clk);
    trig_drv   = 4'b0100;
    continuous = 1'b1;
    set_ivl(24'd4);
    pulse_start();
    cnt = 0;
    while (cur_chan != 2'd1 && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    check("stop_reach_ch1", 32'(cnt < 500), 1);
    pulse_stop();
    wait_idle("stop", cyc);
    check("stop_done_pulses", 32'(done_cnt - d0), 1);
    check("stop_cur_chan", 32'(cur_chan), 0);
    rd(2, d);
    check("stop_res2", 32'(d), 4);

    // Pending stop must have cleared: continuous runs several scans now.
    d0 = done_cnt;
    pulse_start();
    cnt = 0;
    while ((done_cnt - d0) < 2 && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    check("cont_two_scans", 32'(cnt < 1000), 1);
    pulse_stop();
    wait_idle("cont", cyc);
    check("cont_done_pulses", 32'(done_cnt - d0), 3);
    continuous = 1'b0;

    // Interval rewrite mid-MEASURE on channel 2 reissues LOAD on channel 2.
    @(negedge clk);
    trig_drv = 4'b1111;
    set_ivl(24'd10);
    pulse_start();
    cnt = 0;
    while (!(state_dbg == 3'd3 && cur_chan == 2'd2) && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    check("iwr_reach_meas2", 32'(cnt < 1000), 1);
    repeat (3) @(negedge clk);
    interval_in = 24'd8;
    interval_wr = 1'b1;
    @(negedge clk);
    interval_wr = 1'b0;
    check("iwr_state_load", 32'(state_dbg), 1);
    check("iwr_chan", 32'(cur_chan), 2);
    wait_idle("iwr", cyc);
    rd(1, d);
    check("iwr_res1", 32'(d), 10);
    rd(2, d);
    check("iwr_res2", 32'(d), 8);
    rd(3, d);
    check("iwr_res3", 32'(d), 8);

    // Reset during MEASURE abandons the scan and clears results.
    @(negedge clk);
    trig_drv = 4'b1000;
    rd_addr  = 2'd3;
    set_ivl(24'd10);
    pulse_start();
    cnt = 0;
    while (state_dbg != 3'd3 && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    check("mrst_reach_meas", 32'(cnt < 500), 1);
    check("mrst_rd_before", 32'(rd_data), 8);
    d0 = done_cnt;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", 32'(busy), 0);
    check("mrst_scan_done", 32'(scan_done), 0);
    check("mrst_cur_chan", 32'(cur_chan), 0);
    check("mrst_rd_data", 32'(rd_data), 0);
    check("mrst_state", 32'(state_dbg), 0);
`ifdef RATE_SCANNER_THRESH_EN
    check("mrst_over_mask", 32'(over_mask), 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("mrst_no_done", 32'(done_cnt - d0), 0);
    rd(2, d);
    check("mrst_res2_cleared", 32'(d), 0);

    d0 = done_cnt;
    @(negedge clk);
    trig_drv = 4'b0010;
    set_ivl(24'd5);
    pulse_start();
    wait_idle("restart", cyc);
    check_rng("restart_cycles", cyc, NCH * 12 - 2 * NCH, NCH * 12 + 2 * NCH);
    check("restart_done_pulses", 32'(done_cnt - d0), 1);
    rd(1, d);
    check("restart_res1", 32'(d), 5);
    rd(3, d);
    check("restart_res3", 32'(d), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dsp_rate_scanner.md
DSP_RATE_SCANNER -- requirements
Module: dsp_rate_scanner

Interface
REQ-001 Parameter NCHAN, default 8, meaning number of scanned input channels (2..64).
REQ-002 Parameter INTERVAL_INIT, default 24'd125000, meaning interval register reset value in clocks.
REQ-003 Port clk  input  1  meaning single clock for all logic.
REQ-004 Port rst_n  input  1  meaning asynchronous active-low reset.
REQ-005 Port trig_in  input  NCHAN  meaning per-channel count-enable levels, synchronous to clk.
REQ-006 Port interval_in  input  24  meaning new measurement interval in clocks; 0 means 2^24.
REQ-007 Port interval_wr  input  1  meaning single-cycle strobe that loads interval_in.
REQ-008 Port start  input  1  meaning single-cycle strobe that begins a scan.
REQ-009 Port continuous  input  1  meaning restart at channel 0 after each completed scan.
REQ-010 Port stop  input  1  meaning single-cycle strobe that ends scanning after the current scan.
REQ-011 Port busy  output  1  meaning high in every state except IDLE.
REQ-012 Port scan_done  output  1  meaning one-cycle pulse when the last channel's result is written.
REQ-013 Port cur_chan  output  clog2(NCHAN)  meaning channel under measurement.
REQ-014 Port rd_addr  input  clog2(NCHAN)  meaning result readback address.
REQ-015 Port rd_data  output  25  meaning result[rd_addr], registered, 1-clock latency.

Function
REQ-016 Counting SHALL use one dsp_timed_counter instance with count_in = registered trig_in[cur_chan].
REQ-017 States SHALL be IDLE, LOAD, DISCARD, MEASURE and STORE.
REQ-018 IDLE SHALL move to LOAD on start; start SHALL be ignored in any other state.
REQ-019 LOAD SHALL last 1 cycle, assert interval_load with the interval register, then go to DISCARD.
REQ-020 DISCARD SHALL wait for the first count_out_valid and then go to MEASURE; this drops the interval that is contaminated by the mux/A-B register skew and the dead clock after a load.
REQ-021 MEASURE SHALL latch count_out into result[cur_chan] on the next count_out_valid and then go to STORE.
REQ-022 STORE, when cur_chan < NCHAN-1, SHALL increment cur_chan and go to LOAD.
REQ-023 STORE, when cur_chan = NCHAN-1, SHALL pulse scan_done, set cur_chan to 0, and go to LOAD if continuous=1 and no stop is pending, otherwise to IDLE.
REQ-024 stop SHALL set a pending flag while busy; that flag SHALL clear on entry to IDLE, and stop SHALL be ignored in IDLE.
REQ-025 interval_wr SHALL update the interval register in any state.
REQ-026 If interval_wr arrives while in DISCARD or MEASURE, the FSM SHALL go to LOAD on the same cur_chan next cycle and discard the partial measurement.
REQ-027 Results SHALL be 25 bits unsigned, full-scale 2^24, and SHALL never saturate or wrap.
REQ-028 Result storage SHALL be NCHAN x 25 registers, cleared only by reset; unwritten channels read 0.
REQ-029 Per-channel scan time SHALL be 1 + 2*interval + 1 clocks, with a tolerance of +-2 clocks.

Reset
REQ-030 Reset SHALL force state IDLE, cur_chan 0, busy 0, scan_done 0, rd_data 0, all results 0, stop-pending 0, and interval register INTERVAL_INIT.
REQ-031 Reset asserted mid-scan SHALL abandon the scan with no scan_done pulse.
REQ-032 The first start after reset release SHALL behave as from cold.

Configuration
REQ-033 With RATE_SCANNER_THRESH_EN defined, the module SHALL add input thresh_in[24:0] and output over_mask[NCHAN-1:0].
REQ-034 With RATE_SCANNER_THRESH_EN defined, bit c of over_mask SHALL be set on the STORE of channel c when result > thresh_in, cleared when result <= thresh_in, and reset to 0.
REQ-035 Without RATE_SCANNER_THRESH_EN, these ports and the comparator logic SHALL be absent.

Structure
REQ-036 The FSM state enum and CHW = clog2(NCHAN) helper SHALL live in shared package dsp_scan_pkg.
REQ-037 The only sub-module SHALL be dsp_timed_counter; the FSM, mux and result registers stay in this module.

Verification
REQ-038 Scenario: NCHAN=4, interval 10, trig_in=4'b1000, start -> result[3]=10, result[0..2]=0, one scan_done pulse, then busy=0.
REQ-039 Scenario: trig_in[1] toggling every clock, interval 20 -> result[1]=10 (+-1).
REQ-040 Scenario: continuous=1 with stop pulsed during channel 1 -> the scan completes through channel 3, scan_done fires once, then IDLE.
REQ-041 Scenario: interval_wr with value 8 mid-MEASURE on channel 2 -> LOAD reissued on channel 2, and with trig high result[2]=8.
REQ-042 Scenario: rst_n low during MEASURE -> all outputs 0 immediately, no scan_done, and a restart succeeds.
REQ-043 Scenario: RATE_SCANNER_THRESH_EN with thresh_in=5, result values 10 and 3 -> over_mask bits 1 and 0 respectively.
